// File: rtl/spi_ram_ctrl_if.sv
// Command/response bus between the SPI slave serializer and the RAM command controller.
interface spi_ram_ctrl_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_err;

    // SPI slave side: delivers command words, shifts out read bytes
    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        input  cmd_err
    );

    // Controller side
    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        output cmd_err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI command words into write/read accesses of an internal byte RAM
// and returns read bytes, held valid for a fixed number of cycles, for MISO shift-out.
module spi_ram_ctrl #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned AUTO_INC  = 1,
    parameter int unsigned TX_HOLD   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TX_HOLD + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_TX      = 2'd2;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [7:0]           mem [MEM_DEPTH];

    logic [1:0]           state_q,    state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q,  rd_addr_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           tx_data_q,  tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 cmd_err_q,  cmd_err_d;

    logic                 accept_c;
    logic                 rd_armed_c;
    logic                 mem_we_c;
    logic [ADDR_SIZE-1:0] mem_waddr_c;
    logic [7:0]           mem_wdata_c;
    logic [1:0]           op_c;
    logic [ADDR_SIZE-1:0] payload_c;

    // Command decode, sequencing FSM and tx hold countdown
    always_comb begin
        rx_valid_d  = bus.rx_valid;
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        tx_data_d   = tx_data_q;
        cmd_err_d   = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr_q;
        mem_wdata_c = bus.rx_data[7:0];
        op_c        = bus.rx_data[9:8];
        payload_c   = bus.rx_data[ADDR_SIZE-1:0];
        accept_c    = bus.rx_valid & ~rx_valid_q;
        rd_armed_c  = (state_q == S_RD_WAIT);
        cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

        if (state_q == S_TX && cnt_d == '0) begin
            state_d = S_IDLE;
        end

        if (accept_c) begin
            case (op_c)
                OP_WR_ADDR: wr_addr_d = payload_c;
                OP_WR_DATA: begin
                    mem_we_c = 1'b1;
                    if (AUTO_INC != 0) begin
                        wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
                    end
                end
                OP_RD_ADDR: begin
                    rd_addr_d = payload_c;
                    state_d   = S_RD_WAIT;
                end
                OP_RD_DATA: begin
                    if (rd_armed_c) begin
                        tx_data_d = mem[rd_addr_q];
                        cnt_d     = CNT_W'(TX_HOLD);
                        state_d   = S_TX;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        tx_valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            cnt_q      <= '0;
            rx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            cnt_q      <= cnt_d;
            rx_valid_q <= rx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // RAM has no reset; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: directed command sequences push expected
// responses; a negedge monitor pops them as the DUT presents reads or errors.
module tb_spi_ram_ctrl;

    localparam int unsigned TX_HOLD = 8;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    spi_ram_ctrl_if bus ();

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8),
        .AUTO_INC  (1),
        .TX_HOLD   (TX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One command: rx_valid held high for 'hold' cycles, then low for at least one
    task automatic send(input logic [9:0] w, input int hold = 1);
        @(posedge clk);
        #1;
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic rd_ok(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
        send(10'h300);
    endtask

    task automatic rd_bad();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
        send(10'h300);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: a read event is tx_valid rising or tx_data changing while valid
    logic       prev_v;
    logic [7:0] prev_d;
    int         run;
    initial begin
        prev_v = 1'b0;
        prev_d = 8'h00;
        run    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                prev_d = bus.tx_data;
                run    = 0;
            end else begin
                exp_t e;
                bit   ev;
                ev = bus.tx_valid && (!prev_v || bus.tx_data != prev_d);
                if (bus.cmd_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd_err", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd_err_kind", 1, int'(e.is_err));
                    end
                end
                if (ev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_read", int'(bus.tx_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("read_kind", 0, int'(e.is_err));
                        check("read_data", int'(bus.tx_data), int'(e.data));
                    end
                    run = 1;
                end else if (bus.tx_valid) begin
                    run++;
                end
                if (prev_v && !bus.tx_valid) begin
                    check("tx_valid_len", run, int'(TX_HOLD));
                end
                prev_v = bus.tx_valid;
                prev_d = bus.tx_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 10'h000;
        #1;
        check("rst_tx_valid", int'(bus.tx_valid), 0);
        check("rst_tx_data",  int'(bus.tx_data),  0);
        check("rst_cmd_err",  int'(bus.cmd_err),  0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Read-data with nothing armed
        rd_bad();
        idle(4);

        // Basic write then read
        send(10'h005);
        send(10'h1A5);
        send(10'h205);
        rd_ok(8'hA5);
        idle(12);

        // Write-address auto-increment wraps 0xFF -> 0x00
        send(10'h0FF);
        send(10'h111);
        send(10'h122);
        send(10'h200);
        rd_ok(8'h22);
        idle(12);
        send(10'h2FF);
        rd_ok(8'h11);
        idle(12);

        // Second read-data after one arm is illegal and leaves tx_data alone
        send(10'h205);
        rd_ok(8'hA5);
        rd_bad();
        check("tx_data_after_err", int'(bus.tx_data), 8'hA5);
        idle(12);

        // rx_valid held high for 5 cycles writes exactly once
        send(10'h011);
        send(10'h199);
        send(10'h010);
        send(10'h1C3, 5);
        send(10'h210);
        rd_ok(8'hC3);
        idle(12);
        send(10'h211);
        rd_ok(8'h99);
        idle(12);
        send(10'h15A);
        send(10'h211);
        rd_ok(8'h5A);
        idle(12);

        // Back-to-back reads: second accepted while tx_valid still high
        send(10'h020);
        send(10'h13C);
        send(10'h021);
        send(10'h17E);
        send(10'h220);
        rd_ok(8'h3C);
        send(10'h221);
        rd_ok(8'h7E);
        idle(12);

        // Asynchronous reset in the middle of a tx hold
        send(10'h205);
        rd_ok(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_valid", int'(bus.tx_valid), 0);
        check("midrst_tx_data",  int'(bus.tx_data),  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_bad();
        idle(12);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
